// File: rtl/sdp_ram_arbiter.sv
// rtl/sdp_ram_arbiter.sv - round-robin/fixed arbiter sharing one simple dual-port RAM
module sdp_ram_arbiter #(
    parameter int               DATA_WIDTH = 8,
    parameter int               ADDR_WIDTH = 8,
    parameter int               NUM_REQ    = 4,
    parameter int               RD_LATENCY = 1,
    parameter logic [8*11-1:0]  ARB_MODE   = "round_robin",
    localparam int              BYTE_VALID_WIDTH = DATA_WIDTH / 8,
    localparam int              ID_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NUM_REQ-1:0]                   wr_valid_i,
    output logic [NUM_REQ-1:0]                   wr_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        wr_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]        wr_data_i,
    input  logic [NUM_REQ*BYTE_VALID_WIDTH-1:0]  wr_byte_valid_i,
    input  logic [NUM_REQ-1:0]                   rd_valid_i,
    output logic [NUM_REQ-1:0]                   rd_ready_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]        rd_addr_i,
    output logic                                 rsp_valid_o,
    output logic [ID_WIDTH-1:0]                  rsp_id_o,
    output logic [DATA_WIDTH-1:0]                rsp_data_o,
    output logic                                 ram_wr_en_o,
    output logic [ADDR_WIDTH-1:0]                ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0]                ram_wr_data_o,
    output logic [BYTE_VALID_WIDTH-1:0]          ram_wr_byte_valid_o,
    output logic                                 ram_rd_en_o,
    output logic [ADDR_WIDTH-1:0]                ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0]                ram_rd_data_i
);

    localparam logic [8*11-1:0] MODE_RR    = "round_robin";
    localparam logic [8*11-1:0] MODE_FIXED = "fixed";
    localparam logic            IS_FIXED   = (ARB_MODE == MODE_FIXED);

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "sdp_ram_arbiter: RD_LATENCY must be 1 or 2");
    end
    if (ARB_MODE != MODE_RR && ARB_MODE != MODE_FIXED) begin : g_bad_mode
        $fatal(1, "sdp_ram_arbiter: ARB_MODE must be round_robin or fixed");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_shape
        $fatal(1, "sdp_ram_arbiter: NUM_REQ must be 2..8 and DATA_WIDTH a multiple of 8");
    end

    // Returns {found, index}: first valid at or after the pointer, modulo NUM_REQ.
    function automatic logic [ID_WIDTH:0] f_pick(input logic [NUM_REQ-1:0] v,
                                                 input logic [ID_WIDTH-1:0] p);
        logic [ID_WIDTH:0]   res;
        logic [ID_WIDTH-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = ID_WIDTH'((int'(p) + k) % NUM_REQ);
            if (v[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [ID_WIDTH-1:0]   r_wr_ptr;
    logic [ID_WIDTH-1:0]   r_rd_ptr;
    logic [RD_LATENCY-1:0] r_pipe_vld;
    logic [ID_WIDTH-1:0]   r_pipe_id [RD_LATENCY];

    logic                  w_wr_any;
    logic                  w_rd_any;
    logic [ID_WIDTH-1:0]   w_wr_idx;
    logic [ID_WIDTH-1:0]   w_rd_idx;
    logic                  w_wr_hs;
    logic                  w_rd_hs;

    assign {w_wr_any, w_wr_idx} = f_pick(wr_valid_i, r_wr_ptr);
    assign {w_rd_any, w_rd_idx} = f_pick(rd_valid_i, r_rd_ptr);
    assign w_wr_hs = w_wr_any & ~rst_i;
    assign w_rd_hs = w_rd_any & ~rst_i;

    always_comb begin
        wr_ready_o          = '0;
        rd_ready_o          = '0;
        ram_wr_addr_o       = '0;
        ram_wr_data_o       = '0;
        ram_wr_byte_valid_o = '0;
        ram_rd_addr_o       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_wr_any && w_wr_idx == ID_WIDTH'(i)) begin
                wr_ready_o[i]       = ~rst_i;
                ram_wr_addr_o       = wr_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                ram_wr_data_o       = wr_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                ram_wr_byte_valid_o = wr_byte_valid_i[i*BYTE_VALID_WIDTH +: BYTE_VALID_WIDTH];
            end
            if (w_rd_any && w_rd_idx == ID_WIDTH'(i)) begin
                rd_ready_o[i] = ~rst_i;
                ram_rd_addr_o = rd_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign ram_wr_en_o = w_wr_hs;
    // Stage valids keep the RAM output register advancing while reads drain.
    assign ram_rd_en_o = w_rd_hs | (|r_pipe_vld);
    assign rsp_valid_o = r_pipe_vld[RD_LATENCY-1];
    assign rsp_id_o    = r_pipe_id[RD_LATENCY-1];
    assign rsp_data_o  = ram_rd_data_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pipe_vld <= '0;
            for (int k = 0; k < RD_LATENCY; k++) r_pipe_id[k] <= '0;
        end else begin
            r_pipe_vld[0] <= w_rd_hs;
            r_pipe_id[0]  <= w_rd_idx;
            for (int k = 1; k < RD_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
            if (!IS_FIXED) begin
                if (w_wr_hs)
                    r_wr_ptr <= (w_wr_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_wr_idx + 1'b1;
                if (w_rd_hs)
                    r_rd_ptr <= (w_rd_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_rd_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// tb/tb_sdp_ram_arbiter.sv - directed self-checking bench for sdp_ram_arbiter
module tb_sdp_ram_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Main instance: 32-bit words, 4 requesters, 2-cycle read latency, round robin
    logic [3:0]   wr_valid, wr_ready, rd_valid, rd_ready;
    logic [31:0]  wr_addr, rd_addr;
    logic [127:0] wr_data;
    logic [15:0]  wr_bv;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_data;
    logic         ram_wr_en, ram_rd_en;
    logic [7:0]   ram_wr_addr, ram_rd_addr;
    logic [31:0]  ram_wr_data, ram_rd_data;
    logic [3:0]   ram_wr_bv;

    sdp_ram_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .NUM_REQ(4), .RD_LATENCY(2), .ARB_MODE("round_robin")
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_addr_i(wr_addr),
        .wr_data_i(wr_data), .wr_byte_valid_i(wr_bv),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready), .rd_addr_i(rd_addr),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
        .ram_wr_en_o(ram_wr_en), .ram_wr_addr_o(ram_wr_addr), .ram_wr_data_o(ram_wr_data),
        .ram_wr_byte_valid_o(ram_wr_bv), .ram_rd_en_o(ram_rd_en), .ram_rd_addr_o(ram_rd_addr),
        .ram_rd_data_i(ram_rd_data)
    );

    // Behavioural read-first RAM with two output registers
    logic [31:0] mem [256];
    logic [31:0] q1, q2;
    always @(posedge clk) begin
        if (ram_rd_en) begin
            q1 <= mem[ram_rd_addr];
            q2 <= q1;
        end
        if (ram_wr_en)
            for (int b = 0; b < 4; b++)
                if (ram_wr_bv[b]) mem[ram_wr_addr][b*8 +: 8] <= ram_wr_data[b*8 +: 8];
    end
    assign ram_rd_data = q2;

    // Fixed-priority instance
    logic [3:0]   f_wr_valid, f_wr_ready, f_rd_valid, f_rd_ready;
    logic [31:0]  f_wr_addr, f_wr_data, f_rd_addr;
    logic [3:0]   f_wr_bv;
    logic         f_rsp_valid, f_ram_wr_en, f_ram_rd_en;
    logic [1:0]   f_rsp_id;
    logic [7:0]   f_rsp_data, f_ram_wr_addr, f_ram_wr_data, f_ram_rd_addr;
    logic [7:0]   f_ram_rd_data = 8'h00;
    logic [0:0]   f_ram_wr_bv;

    sdp_ram_arbiter #(
        .DATA_WIDTH(8), .ADDR_WIDTH(8), .NUM_REQ(4), .RD_LATENCY(1), .ARB_MODE("fixed")
    ) dut_fixed (
        .clk_i(clk), .rst_i(rst),
        .wr_valid_i(f_wr_valid), .wr_ready_o(f_wr_ready), .wr_addr_i(f_wr_addr),
        .wr_data_i(f_wr_data), .wr_byte_valid_i(f_wr_bv),
        .rd_valid_i(f_rd_valid), .rd_ready_o(f_rd_ready), .rd_addr_i(f_rd_addr),
        .rsp_valid_o(f_rsp_valid), .rsp_id_o(f_rsp_id), .rsp_data_o(f_rsp_data),
        .ram_wr_en_o(f_ram_wr_en), .ram_wr_addr_o(f_ram_wr_addr), .ram_wr_data_o(f_ram_wr_data),
        .ram_wr_byte_valid_o(f_ram_wr_bv), .ram_rd_en_o(f_ram_rd_en), .ram_rd_addr_o(f_ram_rd_addr),
        .ram_rd_data_i(f_ram_rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_valid = '0; rd_valid = '0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_bv = '0;
        f_wr_valid = '0; f_rd_valid = '0; f_wr_addr = '0; f_rd_addr = '0;
        f_wr_data = '0; f_wr_bv = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        wr_valid = 4'hF; rd_valid = 4'hF; wr_bv = 16'hFFFF;
        f_wr_valid = 4'hF; f_rd_valid = 4'hF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({wr_ready, rd_ready, f_wr_ready, f_rd_ready} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_ready: got %h expected 0000", {wr_ready, rd_ready, f_wr_ready, f_rd_ready});
        end
        vectors++;
        if ({ram_wr_en, ram_rd_en, rsp_valid, rsp_id} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b expected 00000", {ram_wr_en, ram_rd_en, rsp_valid, rsp_id});
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (wr_ready !== 4'b0001 || rd_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_release_grant: got wr %b rd %b expected 0001 0001", wr_ready, rd_ready);
        end
        vectors++;
        if (ram_wr_en !== 1'b1 || ram_rd_en !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_en: got wr_en %b rd_en %b expected 1 1", ram_wr_en, ram_rd_en);
        end
        tick();
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp;
        do_reset();
        wr_valid = 4'hF; rd_valid = 4'hF; wr_addr = 32'hFFFF_FFFF; wr_bv = '0;
        for (int i = 0; i < 8; i++) begin
            exp = 4'b0001 << (i % 4);
            @(negedge clk);
            vectors++;
            if (wr_ready !== exp || rd_ready !== exp) begin
                miscompares++;
                $display("FAIL rr_all cycle %0d: got wr %b rd %b expected %b", i, wr_ready, rd_ready, exp);
            end
            tick();
        end
        wr_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            @(negedge clk);
            vectors++;
            if (wr_ready !== exp) begin
                miscompares++;
                $display("FAIL rr_pair cycle %0d: got %b expected %b", i, wr_ready, exp);
            end
            tick();
        end
        clear_inputs();
        repeat (3) tick();
    endtask

    task automatic test_byte_enable();
        do_reset();
        wr_valid = 4'b0001; wr_addr[7:0] = 8'h10; wr_data[31:0] = 32'hAABBCCDD; wr_bv[3:0] = 4'b1111;
        tick();
        wr_data[31:0] = 32'h11223344; wr_bv[3:0] = 4'b0101;
        @(negedge clk);
        vectors++;
        if (ram_wr_bv !== 4'b0101 || ram_wr_data !== 32'h11223344 || ram_wr_addr !== 8'h10) begin
            miscompares++;
            $display("FAIL be_write_port: got bv %b data %h addr %h expected 0101 11223344 10",
                     ram_wr_bv, ram_wr_data, ram_wr_addr);
        end
        tick();
        wr_valid = '0;
        rd_valid = 4'b0010; rd_addr[15:8] = 8'h10;
        @(negedge clk);
        vectors++;
        if (rd_ready !== 4'b0010) begin
            miscompares++;
            $display("FAIL be_rd_grant: got %b expected 0010", rd_ready);
        end
        tick();
        rd_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL be_rsp_early: got %b expected 0", rsp_valid);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hAA22CC44) begin
            miscompares++;
            $display("FAIL be_rsp: got v %b id %0d data %h expected 1 1 aa22cc44", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        clear_inputs();
        repeat (2) tick();
    endtask

    task automatic test_read_latency();
        do_reset();
        wr_valid = 4'b0001; wr_bv[3:0] = 4'hF;
        wr_addr[7:0] = 8'h05; wr_data[31:0] = 32'h5555_0005;
        tick();
        wr_addr[7:0] = 8'h06; wr_data[31:0] = 32'h6666_0006;
        tick();
        wr_valid = '0;
        rd_valid = 4'b0101; rd_addr = {8'h00, 8'h05, 8'h00, 8'h06};
        @(negedge clk);
        vectors++;
        if (rd_ready !== 4'b0001 || ram_rd_addr !== 8'h06 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_issue0: got rdy %b addr %h v %b expected 0001 06 0", rd_ready, ram_rd_addr, rsp_valid);
        end
        tick();
        rd_valid = 4'b0100;
        @(negedge clk);
        vectors++;
        if (rd_ready !== 4'b0100 || ram_rd_addr !== 8'h05 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_issue2: got rdy %b addr %h v %b expected 0100 05 0", rd_ready, ram_rd_addr, rsp_valid);
        end
        tick();
        rd_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h6666_0006) begin
            miscompares++;
            $display("FAIL lat_rsp0: got v %b id %0d data %h expected 1 0 66660006", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h5555_0005) begin
            miscompares++;
            $display("FAIL lat_rsp2: got v %b id %0d data %h expected 1 2 55550005", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || ram_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL lat_drain: got v %b rd_en %b expected 0 0", rsp_valid, ram_rd_en);
        end
        tick();
    endtask

    task automatic test_collision();
        do_reset();
        wr_valid = 4'b0001; wr_addr = {24'h0, 8'h20}; wr_data[31:0] = 32'h1; wr_bv = 16'hFFFF;
        tick();
        wr_valid = 4'b0010; wr_addr = {16'h0, 8'h20, 8'h00}; wr_data[63:32] = 32'h2;
        rd_valid = 4'b1000; rd_addr = {8'h20, 24'h0};
        @(negedge clk);
        vectors++;
        if (wr_ready !== 4'b0010 || rd_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL col_grant: got wr %b rd %b expected 0010 1000", wr_ready, rd_ready);
        end
        tick();
        wr_valid = '0;
        @(negedge clk);
        vectors++;
        if (rd_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL col_regrant: got %b expected 1000", rd_ready);
        end
        tick();
        rd_valid = '0;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'h1) begin
            miscompares++;
            $display("FAIL col_old_data: got v %b id %0d data %h expected 1 3 00000001", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_data !== 32'h2) begin
            miscompares++;
            $display("FAIL col_new_data: got v %b id %0d data %h expected 1 3 00000002", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rd_valid = 4'b0001; rd_addr = 32'h10;
        @(negedge clk);
        vectors++;
        if (rd_ready !== 4'b0001) begin
            miscompares++;
            $display("FAIL mid_grant: got %b expected 0001", rd_ready);
        end
        tick();
        rd_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (rsp_valid !== 1'b0 || ram_rd_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_in_reset: got v %b rd_en %b expected 0 0", rsp_valid, ram_rd_en);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_after_release cycle %0d: got %b expected 0", i, rsp_valid);
            end
            tick();
        end
    endtask

    task automatic test_fixed();
        do_reset();
        f_wr_valid = 4'b1001; f_rd_valid = 4'b1001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            vectors++;
            if (f_wr_ready !== 4'b0001 || f_rd_ready !== 4'b0001) begin
                miscompares++;
                $display("FAIL fixed_grant cycle %0d: got wr %b rd %b expected 0001 0001", i, f_wr_ready, f_rd_ready);
            end
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_round_robin();
        test_byte_enable();
        test_read_latency();
        test_collision();
        test_reset_midflight();
        test_fixed();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
